tx_batch_buffer: RTL and testbench
==================================

// Module: tx_batch_buffer
// PURPOSE
// - Byte buffer directly upstream of the FT245 write stage; its Deq port drives that stage's Handshaking port.
// - Batches bytes from the producer and releases a burst only on one of three triggers:
//   - a fill threshold is reached;
//   - an idle timeout expires;
//   - an explicit flush is requested.
// - Batching keeps USB packets full instead of trickling single bytes to the FT245 chip.
// PARAMETERS
// DEPTH      64    storage entries (bytes); power of two, >= 4
// THRESHOLD  32    occupancy that starts a burst; 1 <= THRESHOLD <= DEPTH
// TIMEOUT    1024  idle cycles with data held in FILL before a burst is forced; >= 1
// PORTS
// clock        in   1                  single clock, rising edge
// reset        in   1                  synchronous, active-low (0 = in reset)
// io_Enq_ready out  1                  buffer can accept a byte
// io_Enq_valid in   1                  producer byte available
// io_Enq_bits  in   8                  producer byte
// io_Deq_ready in   1                  write stage ready (= ~TXE_N downstream)
// io_Deq_valid out  1                  byte presented to write stage
// io_Deq_bits  out  8                  byte presented to write stage
// io_Flush     in   1                  one-cycle request: send everything held now
// io_Count     out  $clog2(DEPTH)+1    current occupancy
// BEHAVIOUR
// - Transfers: a transfer fires when valid && ready on the same rising edge; no other combination transfers.
// - Reset values: state=FILL, count=0, pointers=0, idle timer=0, flush_pend=0.
// - Outputs during and after reset: io_Deq_valid=0, io_Count=0, io_Enq_ready=1.
// - io_Enq_ready = (count != DEPTH).
//   - No bypass path: when full, ready stays 0 even if a Deq fires in the same cycle.
// - io_Deq_valid = (state == SEND) && (count != 0).
// - io_Deq_bits = mem[rd_ptr], combinational read.
//   - Bits stay stable while valid && !ready.
//   - Once asserted, valid drops only after the fire or on reset.
// - Latency: a byte enqueued at edge N is visible on Deq no earlier than cycle N+1.
// - Simultaneous Enq and Deq fire: count is unchanged; both pointers advance.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
// - Count is a separate register with range 0..DEPTH. It never over- or underflows.
// - FSM with 2 states: FILL and SEND.
//   - FILL -> SEND when count != 0 AND any of:
//     - count >= THRESHOLD;
//     - idle == TIMEOUT-1;
//     - io_Flush;
//     - flush_pend.
//   - SEND -> FILL when the next count is 0 (Deq fires with count==1 and no Enq fire).
//   - Enq is accepted in both states. Bytes arriving during SEND are drained in the same burst.
// - Idle timer:
//   - Increments in FILL when count != 0 and no Enq fire.
//   - Clears on any Enq fire, on entering SEND, and whenever count == 0.
//   - Saturates at TIMEOUT-1.
// - io_Flush:
//   - Asserted with count == 0: sets flush_pend.
//   - flush_pend triggers a SEND as soon as the first byte arrives, then clears.
//   - Asserted in SEND: ignored.
// - io_Flush and an Enq fire in the same cycle: the Enq'd byte is included in the burst.
// - Reset mid-burst: all contents are discarded and io_Deq_valid falls in the reset cycle.
// - Data is never reordered, duplicated or dropped outside reset.
// STRUCTURE
// - Package tx_batch_pkg holds:
//   - state typedef {FILL, SEND};
//   - BYTE_W=8;
//   - localparam helpers PTR_W=$clog2(DEPTH) and CNT_W=PTR_W+1.
// - Sub-module byte_fifo_mem: DEPTH x 8 register array with a 1 write port (sync) and 1 read port (async).
// - FSM, pointers, count and idle timer live in the top module.
// TESTING
// 1. Reset then idle, Enq off:
//    -> Deq_valid=0, Count=0, Enq_ready=1 for 2000 cycles.
// 2. Enq 31 bytes 0x00..0x1E back-to-back, Deq_ready=1:
//    -> no Deq while Count<32.
//    - One more byte 0x1F -> SEND on the next cycle.
//    - 32 bytes emerge in order 0x00..0x1F.
//    - Return to FILL with Count=0.
// 3. Enq 5 bytes, then stop:
//    -> Deq_valid rises exactly TIMEOUT idle cycles after the 5th Enq.
//    - 5 bytes drain, then FILL.
// 4. Enq 3 bytes, pulse io_Flush:
//    -> SEND next cycle; 3 bytes drain.
//    - Flush with Count=0, then 1 byte 12 cycles later -> that byte is sent without waiting for the timeout.
// 5. Fill to 64 with Deq_ready=0:
//    -> Enq_ready=0, Count=64, Deq_bits holds the first byte.
//    - Toggle Deq_ready with a random pattern while the producer keeps pushing -> order preserved, no loss, no overflow.
// 6. Assert reset (0) mid-burst at Count=20:
//    -> next cycle Deq_valid=0, Count=0, state FILL.
//    - Post-reset stream unaffected by old data.

Source files
------------

// File: rtl/tx_batch_pkg.sv
// Shared types and widths for the FT245 transmit batching buffer.
package tx_batch_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEPTH_DEF = 64;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/byte_fifo_mem.sv
// DEPTH x BYTE_W register array: one synchronous write port, one asynchronous read port.
module byte_fifo_mem
    import tx_batch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [BYTE_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [BYTE_W-1:0]        rdata
);

    logic [BYTE_W-1:0] mem_r [DEPTH];

    // Write port; storage needs no reset because occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/tx_batch_buffer.sv
// Byte buffer feeding the FT245 write stage: holds bytes until a fill threshold,
// an idle timeout or a flush request releases them as one burst.
module tx_batch_buffer
    import tx_batch_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int THRESHOLD = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_Enq_ready,
    input  logic                   io_Enq_valid,
    input  logic [BYTE_W-1:0]      io_Enq_bits,
    input  logic                   io_Deq_ready,
    output logic                   io_Deq_valid,
    output logic [BYTE_W-1:0]      io_Deq_bits,
    input  logic                   io_Flush,
    output logic [$clog2(DEPTH):0] io_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_THR_C  = CW'(THRESHOLD);
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
    localparam logic [IW-1:0] IDLE_ONE_C = IW'(1);
    localparam logic [IW-1:0] IDLE_MAX_C = IW'(TIMEOUT - 1);

    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [IW-1:0]     idle_r;
    logic [IW-1:0]     idle_nxt_s;
    logic              flush_pend_r;
    logic              flush_pend_nxt_s;
    logic              enq_fire_s;
    logic              deq_fire_s;
    logic              trigger_s;
    logic [BYTE_W-1:0] rd_data_s;

    byte_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (enq_fire_s),
        .waddr (wr_ptr_r),
        .wdata (io_Enq_bits),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Handshakes; outputs are forced to their idle values while reset is held.
    always_comb begin
        io_Enq_ready = !reset || (count_r != CNT_FULL_C);
        io_Deq_valid = reset && (state_r == SEND) && (count_r != CNT_ZERO_C);
        io_Deq_bits  = rd_data_s;
        io_Count     = reset ? count_r : CNT_ZERO_C;
        enq_fire_s   = io_Enq_valid && (count_r != CNT_FULL_C);
        deq_fire_s   = io_Deq_valid && io_Deq_ready;
    end

    // Occupancy update; a simultaneous enqueue and dequeue leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Burst release decision and return to batching once the buffer empties.
    always_comb begin
        trigger_s   = (count_r != CNT_ZERO_C) &&
                      ((count_r >= CNT_THR_C) || (idle_r == IDLE_MAX_C) ||
                       io_Flush || flush_pend_r);
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                if (trigger_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            SEND: begin
                if (count_nxt_s == CNT_ZERO_C) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = FILL;
        endcase
    end

    // A flush seen while empty is remembered until the first byte launches a burst.
    always_comb begin
        flush_pend_nxt_s = flush_pend_r;
        if ((state_r == FILL) && (state_nxt_s == SEND)) begin
            flush_pend_nxt_s = 1'b0;
        end else if (io_Flush && (count_r == CNT_ZERO_C)) begin
            flush_pend_nxt_s = 1'b1;
        end else begin
            flush_pend_nxt_s = flush_pend_r;
        end
    end

    // Idle timer only runs while bytes sit in FILL with no new arrivals.
    always_comb begin
        idle_nxt_s = idle_r;
        if ((state_r != FILL) || (state_nxt_s == SEND) || enq_fire_s ||
            (count_r == CNT_ZERO_C)) begin
            idle_nxt_s = {IW{1'b0}};
        end else if (idle_r != IDLE_MAX_C) begin
            idle_nxt_s = idle_r + IDLE_ONE_C;
        end else begin
            idle_nxt_s = idle_r;
        end
    end

    // State, pointers, occupancy and timer registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= FILL;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= CNT_ZERO_C;
            idle_r       <= {IW{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            idle_r       <= idle_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

endmodule

// File: tb/tb_tx_batch_buffer.sv
// Directed bench for tx_batch_buffer: threshold, timeout, flush, full/backpressure and reset bursts.
module tb_tx_batch_buffer;

    localparam int DEPTH     = 64;
    localparam int THRESHOLD = 32;
    localparam int TIMEOUT   = 1024;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_Enq_valid = 1'b0;
    logic [7:0] io_Enq_bits = 8'h00;
    logic       io_Deq_ready = 1'b0;
    logic       io_Flush = 1'b0;
    logic       io_Enq_ready;
    logic       io_Deq_valid;
    logic [7:0] io_Deq_bits;
    logic [6:0] io_Count;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] model[$];
    logic [7:0] nxt;
    int         k;

    tx_batch_buffer #(
        .DEPTH     (DEPTH),
        .THRESHOLD (THRESHOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_Enq_ready (io_Enq_ready),
        .io_Enq_valid (io_Enq_valid),
        .io_Enq_bits  (io_Enq_bits),
        .io_Deq_ready (io_Deq_ready),
        .io_Deq_valid (io_Deq_valid),
        .io_Deq_bits  (io_Deq_bits),
        .io_Flush     (io_Flush),
        .io_Count     (io_Count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        io_Enq_valid = 1'b1;
        io_Enq_bits  = b;
        if (io_Enq_ready) model.push_back(b);
        tick();
        io_Enq_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        io_Flush = 1'b1;
        tick();
        io_Flush = 1'b0;
    endtask

    task automatic drain_all(input int bound, input string tag);
        int c = 0;
        io_Deq_ready = 1'b1;
        while (model.size() != 0 && c < bound) begin
            if (io_Deq_valid) begin
                check_val(tag, 32'(io_Deq_bits), 32'(model[0]));
                void'(model.pop_front());
            end
            tick();
            c++;
        end
        check_val({tag, "_left"}, 32'(model.size()), 32'd0);
        check_val({tag, "_cnt0"}, 32'(io_Count), 32'd0);
        check_val({tag, "_vld0"}, 32'(io_Deq_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset, then idle with no producer traffic
        repeat (3) tick();
        check_val("rst_vld", 32'(io_Deq_valid), 32'd0);
        check_val("rst_cnt", 32'(io_Count), 32'd0);
        check_val("rst_rdy", 32'(io_Enq_ready), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            check_val("idle_vld", 32'(io_Deq_valid), 32'd0);
            check_val("idle_cnt", 32'(io_Count), 32'd0);
            check_val("idle_rdy", 32'(io_Enq_ready), 32'd1);
        end

        // 2: threshold trigger
        io_Deq_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            push(8'(i));
            check_val("thr_hold_vld", 32'(io_Deq_valid), 32'd0);
            check_val("thr_hold_cnt", 32'(io_Count), 32'(i + 1));
        end
        push(8'h1F);
        check_val("thr_32_vld", 32'(io_Deq_valid), 32'd0);
        check_val("thr_32_cnt", 32'(io_Count), 32'd32);
        tick();
        check_val("thr_send", 32'(io_Deq_valid), 32'd1);
        drain_all(100, "thr_drain");

        // 3: idle timeout trigger
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        k = 0;
        while (!io_Deq_valid && k < 3000) begin
            tick();
            k++;
        end
        check_val("tmo_cycles", 32'(k), 32'(TIMEOUT));
        drain_all(20, "tmo_drain");

        // 4: flush with data held, then flush while empty
        push(8'h51);
        push(8'h52);
        push(8'h53);
        pulse_flush();
        check_val("fl_send", 32'(io_Deq_valid), 32'd1);
        drain_all(20, "fl_drain");
        pulse_flush();
        repeat (11) tick();
        push(8'h77);
        tick();
        check_val("flp_send", 32'(io_Deq_valid), 32'd1);
        drain_all(10, "flp_drain");

        // 5: fill to full under backpressure, then random Deq_ready
        io_Deq_ready = 1'b0;
        for (int i = 0; i < 64; i++) push(8'(8'h40 + i));
        check_val("full_rdy", 32'(io_Enq_ready), 32'd0);
        check_val("full_cnt", 32'(io_Count), 32'd64);
        check_val("full_vld", 32'(io_Deq_valid), 32'd1);
        check_val("full_bits", 32'(io_Deq_bits), 32'h40);
        push(8'hEE);
        check_val("ovf_cnt", 32'(io_Count), 32'd64);
        check_val("ovf_bits", 32'(io_Deq_bits), 32'h40);
        nxt = 8'h80;
        for (int c = 0; c < 300; c++) begin
            io_Deq_ready = 1'($urandom_range(0, 1));
            io_Enq_valid = (c < 200);
            io_Enq_bits  = nxt;
            if (io_Deq_valid && io_Deq_ready) begin
                if (model.size() == 0) begin
                    check_val("bp_spurious", 32'd1, 32'd0);
                end else begin
                    check_val("bp_order", 32'(io_Deq_bits), 32'(model[0]));
                    void'(model.pop_front());
                end
            end
            if (io_Enq_valid && io_Enq_ready) begin
                model.push_back(nxt);
                nxt = nxt + 8'h01;
            end
            tick();
            check_val("bp_cnt", 32'(io_Count), 32'(model.size()));
        end
        io_Enq_valid = 1'b0;
        drain_all(2000, "bp_drain");

        // 6: reset in the middle of a burst
        io_Deq_ready = 1'b0;
        for (int i = 0; i < 25; i++) push(8'(8'h10 + i));
        pulse_flush();
        io_Deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("mid_bits", 32'(io_Deq_bits), 32'(model[0]));
            void'(model.pop_front());
            tick();
        end
        check_val("mid_cnt", 32'(io_Count), 32'd20);
        check_val("mid_vld", 32'(io_Deq_valid), 32'd1);
        reset = 1'b0;
        tick();
        check_val("mrst_vld", 32'(io_Deq_valid), 32'd0);
        check_val("mrst_cnt", 32'(io_Count), 32'd0);
        check_val("mrst_rdy", 32'(io_Enq_ready), 32'd1);
        reset = 1'b1;
        io_Deq_ready = 1'b0;
        model.delete();
        tick();
        check_val("post_vld", 32'(io_Deq_valid), 32'd0);
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        pulse_flush();
        check_val("post_send", 32'(io_Deq_valid), 32'd1);
        drain_all(20, "post_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
